// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit control blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } rx_ctrl_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned DEFAULT_DIV = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Divisor counter producing a one-cycle tick every max(div,1) clocks while enabled.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  logic [DIV_W-1:0] lim;

  // div_q only reloads at a wrap (or while idle) so a new divisor never cuts a period short
  assign lim = (div_q == '0) ? DIV_W'(1) : div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      tick_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      div_q  <= div_i;
      tick_q <= 1'b0;
    end else if (cnt_q == lim - DIV_W'(1)) begin
      cnt_q  <= '0;
      div_q  <= div_i;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + DIV_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: baud tick, config forwarding, byte drain FSM,
// host valid/ready holding register, saturating error counters and interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_type,
  input  logic [1:0]       cfg_thr_val,
  input  logic             irq_rx_en,
  input  logic             irq_err_en,
  input  logic             err_clr,
  output logic             rx_bclk,
  output logic             rx_en,
  output logic             read_en,
  output logic             parity_en,
  output logic             parity_type,
  output logic [1:0]       rx_thr_val,
  input  logic [7:0]       rx_data,
  input  logic             rx_fre,
  input  logic             rx_pe,
  input  logic             rx_ov,
  input  logic             rx_thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_fe,
  output logic             out_pe,
  output logic             out_ov,
  output logic [CNT_W-1:0] fe_count,
  output logic [CNT_W-1:0] pe_count,
  output logic             err_sticky,
  output logic             irq
);

  rx_ctrl_state_t   state_q;
  logic             read_en_q, out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_fe_q, out_pe_q, out_ov_q;
  logic             rx_en_q, parity_en_q, parity_type_q;
  logic [1:0]       rx_thr_val_q;
  logic [CNT_W-1:0] fe_cnt_q, fe_cnt_d, pe_cnt_q, pe_cnt_d;
  logic             sticky_q, sticky_d;
  logic             irq_q, irq_d;
  logic             capture;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en_i   (cfg_en),
    .div_i  (cfg_div),
    .tick_o (rx_bclk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_en_q       <= 1'b0;
      parity_en_q   <= 1'b0;
      parity_type_q <= PARITY_EVEN;
      rx_thr_val_q  <= 2'b00;
    end else begin
      rx_en_q       <= cfg_en;
      parity_en_q   <= cfg_parity_en;
      parity_type_q <= cfg_parity_type;
      rx_thr_val_q  <= cfg_thr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      read_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_fe_q    <= 1'b0;
      out_pe_q    <= 1'b0;
      out_ov_q    <= 1'b0;
    end else if (!cfg_en) begin
      // disabling abandons any byte in flight; out_* keep stale data but are not valid
      state_q     <= IDLE;
      read_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_thr) begin
            state_q   <= READ;
            read_en_q <= 1'b1;
          end
        end
        READ: begin
          state_q   <= CAPTURE;
          read_en_q <= 1'b0;
        end
        CAPTURE: begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          out_data_q  <= rx_data;
          out_fe_q    <= rx_fre;
          out_pe_q    <= rx_pe;
          out_ov_q    <= rx_ov;
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign capture = cfg_en && (state_q == CAPTURE);

  // clear is applied first so an error captured in the same cycle still counts
  always_comb begin
    fe_cnt_d = err_clr ? '0 : fe_cnt_q;
    pe_cnt_d = err_clr ? '0 : pe_cnt_q;
    sticky_d = err_clr ? 1'b0 : sticky_q;
    if (capture) begin
      if (rx_fre && fe_cnt_d != {CNT_W{1'b1}}) fe_cnt_d = fe_cnt_d + CNT_W'(1);
      if (rx_pe  && pe_cnt_d != {CNT_W{1'b1}}) pe_cnt_d = pe_cnt_d + CNT_W'(1);
      sticky_d = sticky_d | rx_fre | rx_pe | rx_ov;
    end
  end

  assign irq_d = (out_valid_q & irq_rx_en) | (sticky_q & irq_err_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_cnt_q <= '0;
      pe_cnt_q <= '0;
      sticky_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      fe_cnt_q <= fe_cnt_d;
      pe_cnt_q <= pe_cnt_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign rx_en       = rx_en_q;
  assign read_en     = read_en_q;
  assign parity_en   = parity_en_q;
  assign parity_type = parity_type_q;
  assign rx_thr_val  = rx_thr_val_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_fe      = out_fe_q;
  assign out_pe      = out_pe_q;
  assign out_ov      = out_ov_q;
  assign fe_count    = fe_cnt_q;
  assign pe_count    = pe_cnt_q;
  assign err_sticky  = sticky_q;
  assign irq         = irq_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver in the interrupt-handler subsystem. Generates the 16x oversampling baud tick, drives the receiver's configuration, and drains each received byte with a `read_en` pulse. It captures data plus error flags into a holding register, presents them to the host over a valid/ready handshake, keeps saturating error counters, and raises a level interrupt.

## Interface
- `DIV_W`, 16, width of baud divisor
- `CNT_W`, 8, width of each saturating error counter
- `clk`  in  1  single system clock; everything is synchronous to its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cfg_en`  in  1  enables receiver and controller
- `cfg_div`  in  DIV_W  clk cycles per baud tick (0 treated as 1)
- `cfg_parity_en`, `cfg_parity_type`  in  1 each  forwarded to receiver (type 0 = even)
- `cfg_thr_val`  in  2  forwarded to receiver `rx_thr_val`
- `irq_rx_en`, `irq_err_en`  in  1 each  interrupt source masks
- `err_clr`  in  1  clears sticky error flag and both counters
- `rx_bclk`  out  1  one-cycle baud tick to receiver `bclk`
- `rx_en`, `read_en`  out  1 each  receiver enable, one-cycle read strobe
- `parity_en`, `parity_type`  out  1 each; `rx_thr_val`  out  2  registered copies of cfg
- `rx_data`  in  8; `rx_fre`, `rx_pe`, `rx_ov`, `rx_thr`  in  1 each  from receiver
- `out_valid`  out  1; `out_ready`  in  1  host handshake
- `out_data`  out  8; `out_fe`, `out_pe`, `out_ov`  out  1 each  captured byte and flags
- `fe_count`, `pe_count`  out  CNT_W  saturating error counters
- `err_sticky`  out  1  any error since last `err_clr`
- `irq`  out  1  registered interrupt request

## Operation
- Baud generator: counter runs while `cfg_en`=1. `rx_bclk`=1 for one cycle when count = max(cfg_div,1)-1, then count returns to 0. `cfg_en`=0 holds the count at 0. A `cfg_div` change takes effect at the next wrap.
- Config outputs: registered from cfg inputs every cycle. `rx_en` = registered `cfg_en`.
- FSM states:
  - IDLE: `rx_thr`=1 and `cfg_en`=1 -> READ.
  - READ: `read_en`=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: latch `rx_data`, `rx_fre`, `rx_pe`, `rx_ov` into `out_*` -> HOLD.
  - HOLD: `out_valid`=1. `out_ready`=1 -> IDLE.
- `rx_thr` is ignored outside IDLE. The receiver keeps buffering and reports its own overrun via `rx_ov`.
- Counters update in CAPTURE: `fe_count`+1 if `rx_fre`, `pe_count`+1 if `rx_pe`. Both saturate at 2^CNT_W-1 and never wrap. `err_sticky` is set if any flag is set.
- `err_clr` zeroes the counters and `err_sticky`. If it coincides with a CAPTURE that carries an error, the result is count = 1 and sticky = 1 (the new event wins).
- `irq` next = (`out_valid` & `irq_rx_en`) | (`err_sticky` & `irq_err_en`), registered.
- `cfg_en` falling in any state: FSM -> IDLE next cycle, `out_valid` cleared, the held byte is dropped, counters are kept.

## Timing
- Reset values: all outputs 0; FSM IDLE; baud counter 0.
- `rx_thr` high at edge N in IDLE -> `read_en` high in cycle N+1 -> capture at edge N+2 -> `out_valid` high from cycle N+3.
- Handshake completes in the cycle where `out_valid`=1 and `out_ready`=1. `out_valid` is low the next cycle. Earliest next `read_en` is 2 cycles after the handshake.
- `out_*` are stable while `out_valid`=1.
- `irq` lags its sources by exactly one cycle.
- Reset asserted mid-transaction returns all state to reset values immediately, without waiting for a clock edge.

## Structure
- Package `uart_pkg`: state enum `rx_ctrl_state_t` (IDLE, READ, CAPTURE, HOLD), `PARITY_EVEN`=0 / `PARITY_ODD`=1, default divisor constant.
- Sub-module `uart_baud_gen`: divisor counter and tick output, reusable by the transmit side.
- FSM, capture registers, counters and irq logic live in `uart_rx_ctrl`.

## Test plan
- `cfg_div`=4, `cfg_en`=1 -> `rx_bclk` pulses every 4th cycle. `cfg_div`=0 -> pulses every cycle. `cfg_en`=0 -> no pulses.
- Receiver model raises `rx_thr` with `rx_data`=0x55, no errors -> `read_en` is one cycle at N+1; `out_valid` at N+3 with `out_data`=0x55; `irq`=1 one cycle later when `irq_rx_en`=1.
- Hold `out_ready`=0 for 10 cycles while `rx_thr` stays high -> exactly one `read_en`, `out_data` stable; after `out_ready`, a second read occurs.
- Byte with `rx_pe`=1 repeated 300 times -> `pe_count`=255 (saturated), `err_sticky`=1; `err_clr` -> counters 0; `err_clr` coincident with an error capture -> count 1.
- `cfg_en` dropped while in HOLD -> `out_valid`=0 and FSM in IDLE next cycle; `rx_en`=0.
- Reset asserted during READ -> all outputs 0 asynchronously; after release, the first byte is received normally.
